// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory environment.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_valid;
  logic [DW-1:0]   if_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_valid;
  logic [DW-1:0]   d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic            stall;
  logic            err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be, stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first; registers
// the granted request until mem_ready, pulses valid back, and aborts after TIMEOUT waits.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);

  logic [1:0]    state_q,     state_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0] mem_be_q,    mem_be_d;
  logic          if_valid_q,  if_valid_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic          d_valid_q,   d_valid_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic          err_q,       err_d;
  logic [CW-1:0] cnt_q,       cnt_d;

  logic d_elig, if_elig, timed_out;

  // A requester still seeing its valid this cycle has just been served, not re-requested.
  assign d_elig    = bus.d_req  & ~d_valid_q;
  assign if_elig   = bus.if_req & ~if_valid_q;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_TO) && !bus.mem_ready;

  always_comb begin
    // NOTE: every next-state value gets a hold/default first so no path infers a latch.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_we ? bus.d_be : {BW{1'b1}};
        end else if (if_elig) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          mem_be_d   = {BW{1'b1}};
        end
      end

      FETCH, DATA: begin
        if (bus.mem_ready || timed_out) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          err_d     = timed_out;
          if (state_q == FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          // Saturates rather than wraps when the timeout is disabled.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the bus registers are reset too, so mem_req drops immediately even mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);
endmodule
